sub_shift_rows_seq: RTL and testbench

Iterative SubBytes + ShiftRows round stage that sits directly upstream of the MixColumns stage and produces its `Data_Raw` input. It accepts one 128-bit AES state over a valid/ready handshake and substitutes one 32-bit row per cycle through four S-box lookups, so a block takes 4 cycles. It applies ShiftRows to each row as it is written, then holds the result in a registered output buffer until downstream accepts it.

---
 rtl/sub_shift_rows_seq.sv | 176 +++++++++++++++++
 tb/tb_sub_shift_rows_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_rows_seq.sv
// -----------------------------------------------------------------------------
// sub_shift_rows_seq
//
// Iterative AES SubBytes + ShiftRows stage feeding MixColumns (Data_Raw).
// One 128-bit state is captured over a valid/ready handshake. One 32-bit row
// is substituted per cycle through four S-box lookups, so a block takes four
// cycles. The result is held in a registered output buffer until downstream
// accepts it.
//
// State layout (shared with MixColumns):
//   row r    -> bits [32r+31:32r]
//   column c -> bits [32r+31-8c -: 8] within that row
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. In_Ready and Out_Valid are registered, so there is no
// combinational path from any input to any output. In_Ready is high only in
// IDLE and Out_Valid only in HOLD, so at most one block is in flight.
//
// Configuration macro: SUB_SHIFT_ROWS_SHIFT_EN
//   defined   : out(r,c) = S(in(r,(c+r) mod 4))  (SubBytes + ShiftRows)
//   undefined : out(r,c) = S(in(r,c))            (SubBytes only)
//
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset, dominates every handshake
//   In_Valid   upstream presents a state on Data_In
//   In_Ready   block can accept a state (registered)
//   Data_In    input state
//   Out_Valid  Data_Out holds a complete result (registered)
//   Out_Ready  downstream accepts Data_Out
//   Data_Out   result, same layout as Data_In
// -----------------------------------------------------------------------------
module sub_shift_rows_seq #(
  parameter int BUS_WIDTH = 128
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [BUS_WIDTH-1:0] Data_In,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [BUS_WIDTH-1:0] Data_Out
);

  generate
    if (BUS_WIDTH != 128) begin : g_bad_width
      $error("sub_shift_rows_seq: BUS_WIDTH must be 128");
    end
  endgenerate

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  // FSM state is kept in a named enum register so checkers can bind to it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [1:0]           row, row_d;
  logic                 in_ready_d, out_valid_d;
  logic                 capture, write_row;
  logic [BUS_WIDTH-1:0] in_reg;
  logic [31:0]          row_in, row_out;
  logic [7:0]           sub_b [4];

  // Next-state and handshake logic.
  always_comb begin
    state_d     = state;
    row_d       = row;
    in_ready_d  = In_Ready;
    out_valid_d = Out_Valid;
    capture     = 1'b0;
    write_row   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (In_Valid && In_Ready) begin
          capture    = 1'b1;
          row_d      = 2'd0;
          in_ready_d = 1'b0;
          state_d    = ST_SUB;
        end
      end
      ST_SUB: begin
        write_row = 1'b1;
        row_d     = row + 2'd1;  // wraps to 0 after row 3
        if (row == 2'd3) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Out_Valid && Out_Ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Row datapath: four S-box lookups, then the optional rotation.
`ifdef SUB_SHIFT_ROWS_SHIFT_EN
  logic [1:0] src_col;
`endif

  always_comb begin
    row_in  = in_reg[32 * row +: 32];
    row_out = '0;
    for (int c = 0; c < 4; c++) begin
      sub_b[c] = sbox(row_in[31 - 8 * c -: 8]);
    end
`ifdef SUB_SHIFT_ROWS_SHIFT_EN
    src_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      // Row r rotates left by r bytes; 2-bit sum gives the mod-4 wrap.
      src_col = 2'(c) + row;
      row_out[31 - 8 * c -: 8] = sub_b[src_col];
    end
`else
    for (int c = 0; c < 4; c++) begin
      row_out[31 - 8 * c -: 8] = sub_b[c];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      row       <= 2'd0;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      in_reg    <= '0;
      Data_Out  <= '0;
    end else begin
      state     <= state_d;
      row       <= row_d;
      In_Ready  <= in_ready_d;
      Out_Valid <= out_valid_d;
      if (capture) begin
        in_reg <= Data_In;
      end
      if (write_row) begin
        Data_Out[32 * row +: 32] <= row_out;
      end
    end
  end

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_shift_rows_seq
//
// Self-checking bench for sub_shift_rows_seq. The reference S-box is derived
// from GF(2^8) inversion plus the affine transform; the reference block
// function applies SubBytes and the ShiftRows rule byte by byte.
// -----------------------------------------------------------------------------
module tb_sub_shift_rows_seq;

  logic         Clk;
  logic         Rst;
  logic         In_Valid;
  logic         In_Ready;
  logic [127:0] Data_In;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [127:0] Data_Out;

  int checks;
  int errors;
  int cycle;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_q [$];

  sub_shift_rows_seq #(.BUS_WIDTH(128)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Data_In   (Data_In),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Data_Out  (Data_Out)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cycle = 0;
  always @(posedge Clk) cycle <= cycle + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x, s;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[v] = s;
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef SUB_SHIFT_ROWS_SHIFT_EN
        src = (c + r) % 4;
`else
        src = c;
`endif
        o[32 * r + 31 - 8 * c -: 8] = sbox_tab[d[32 * r + 31 - 8 * src -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents d until accepted; returns with the bench at edge T+1 plus #1.
  task automatic drive_accept(input logic [127:0] d, output bit ok, output int t_acc);
    bit rdy;
    ok       = 1'b0;
    t_acc    = -1;
    In_Valid = 1'b1;
    Data_In  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      rdy = In_Ready;
      @(posedge Clk);
      if (rdy) begin
        ok    = 1'b1;
        t_acc = cycle;
      end
      #1;
    end
    In_Valid = 1'b0;
  endtask

  // Waits until Out_Valid is seen high; t_seen is the edge that raised it.
  task automatic wait_valid(output bit ok, output int t_seen);
    ok     = 1'b0;
    t_seen = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (Out_Valid) begin
        ok     = 1'b1;
        t_seen = cycle - 1;
      end else begin
        @(posedge Clk);
        #1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", In_Ready);
    end
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", Out_Valid);
    end
    checks++;
    if (Data_Out !== 128'h0) begin
      errors++; $display("FAIL reset_data_out got %h want 0", Data_Out);
    end
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_zero_latency();
    bit ok;
    int t_acc, t_seen;
    Out_Ready = 1'b1;
    drive_accept(128'h0, ok, t_acc);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL zero_accept got timeout want accept");
    end
    checks++;
    if (In_Ready !== 1'b0) begin
      errors++; $display("FAIL zero_in_ready_after_accept got %b want 0", In_Ready);
    end
    wait_valid(ok, t_seen);
    checks++;
    if (!ok || (t_seen - t_acc) != 4) begin
      errors++; $display("FAIL zero_latency got %0d want 4 (ok=%0b)", t_seen - t_acc, ok);
    end
    checks++;
    if (Data_Out !== {16{8'h63}}) begin
      errors++; $display("FAIL zero_data got %h want %h", Data_Out, {16{8'h63}});
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++; $display("FAIL zero_consume got valid=%b ready=%b want 0/1", Out_Valid, In_Ready);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] din [2];
    logic [127:0] want [2];
    bit ok;
    int t_acc, t_seen;
    din[0] = {64'h0, 32'h04050607, 32'h00010203};
    din[1] = 128'hbe2b2a08_e3e28d48_3df4c6f8_19a09ae9;
`ifdef SUB_SHIFT_ROWS_SHIFT_EN
    want[0] = {32'h63636363, 32'h63636363, 32'h6B6FC5F2, 32'h637C777B};
    want[1] = 128'h30aef1e5_5d521198_bfb44127_d4e0b81e;
`else
    want[0] = {32'h63636363, 32'h63636363, 32'hF26B6FC5, 32'h637C777B};
    want[1] = 128'haef1e530_11985d52_27bfb441_d4e0b81e;
`endif
    Out_Ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_accept(din[k], ok, t_acc);
      wait_valid(ok, t_seen);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL vector%0d_valid got timeout want valid", k);
      end
      checks++;
      if (Data_Out !== want[k]) begin
        errors++; $display("FAIL vector%0d_data got %h want %h", k, Data_Out, want[k]);
      end
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_hold_stall();
    logic [127:0] d0, d1, w0;
    bit ok;
    int t_acc, t_seen;
    d0 = rand_state();
    d1 = rand_state();
    w0 = ref_block(d0);
    Out_Ready = 1'b0;
    drive_accept(d0, ok, t_acc);
    wait_valid(ok, t_seen);
    checks++;
    if (!ok || Data_Out !== w0) begin
      errors++; $display("FAIL hold_first got %h want %h", Data_Out, w0);
    end
    for (int i = 0; i < 10; i++) begin
      In_Valid = i[0];
      Data_In  = rand_state();
      @(posedge Clk);
      #1;
      checks++;
      if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || Data_Out !== w0) begin
        errors++;
        $display("FAIL hold_stable cyc%0d got v=%b r=%b d=%h want 1/0/%h",
                 i, Out_Valid, In_Ready, Data_Out, w0);
      end
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got v=%b r=%b want 0/1", Out_Valid, In_Ready);
    end
    drive_accept(d1, ok, t_acc);
    wait_valid(ok, t_seen);
    checks++;
    if (!ok || Data_Out !== ref_block(d1)) begin
      errors++; $display("FAIL hold_next got %h want %h", Data_Out, ref_block(d1));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_mid_sub();
    logic [127:0] d;
    bit ok;
    int t_acc, t_seen;
    Out_Ready = 1'b1;
    drive_accept(rand_state(), ok, t_acc);
    @(posedge Clk);   // edge T+2 writes row 1
    #1;
    Rst = 1'b1;       // sampled on edge T+3, the row-2 write
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Data_Out !== 128'h0) begin
      errors++;
      $display("FAIL midreset got v=%b r=%b d=%h want 0/1/0", Out_Valid, In_Ready, Data_Out);
    end
    d = rand_state();
    drive_accept(d, ok, t_acc);
    wait_valid(ok, t_seen);
    checks++;
    if (!ok || (t_seen - t_acc) != 4 || Data_Out !== ref_block(d)) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d d=%h want 4/%h", t_seen - t_acc, Data_Out, ref_block(d));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    bit acc, con;
    logic [127:0] exp_v;
    sent     = 0;
    recv     = 0;
    In_Valid = 1'b1;
    Data_In  = rand_state();
    for (int i = 0; i < 1000 && recv < 16; i++) begin
      Out_Ready = 1'($urandom_range(0, 1));
      acc = In_Valid && In_Ready;
      con = Out_Valid && Out_Ready;
      if (acc) exp_q.push_back(ref_block(Data_In));
      if (con) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %h want none", Data_Out);
        end else begin
          exp_v = exp_q.pop_front();
          if (Data_Out !== exp_v) begin
            errors++; $display("FAIL b2b_data blk%0d got %h want %h", recv, Data_Out, exp_v);
          end
        end
        recv++;
      end
      @(posedge Clk);
      #1;
      if (acc) begin
        sent++;
        Data_In = rand_state();
        if (sent == 16) In_Valid = 1'b0;
      end
    end
    In_Valid = 1'b0;
    checks++;
    if (recv != 16 || sent != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got sent=%0d recv=%0d left=%0d want 16/16/0", sent, recv, exp_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    Rst       = 1'b1;
    In_Valid  = 1'b0;
    Data_In   = '0;
    Out_Ready = 1'b0;
    build_sbox();
    test_reset();
    test_zero_latency();
    test_vectors();
    test_hold_stall();
    test_reset_mid_sub();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
